// File: rtl/pea_pkg.sv
// Shared types and defaults for the PE array and its configuration sequencer.
package pea_pkg;

    localparam int unsigned N_CFG_BITS_PE            = 16;
    localparam int unsigned CFG_DRAIN_CYCLES_DEFAULT = 4;

    localparam logic [N_CFG_BITS_PE-1:0] CTRL_NOP = '0;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StSwap,
        StDone
    } cfg_seq_state_t;

endpackage

// File: rtl/cfg_shadow_bank.sv
// Shadow/active register bank: single write port into the shadow set and a
// bulk copy of the whole shadow set into the active set.
module cfg_shadow_bank #(
    parameter int unsigned       Width  = 32,
    parameter int unsigned       Depth  = 16,
    parameter logic [Width-1:0]  RstVal = '0,
    localparam int unsigned      IdxW   = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          wr_en_i,
    input  logic [IdxW-1:0]               wr_idx_i,
    input  logic [Width-1:0]              wr_data_i,
    input  logic                          copy_i,
    output logic [Depth-1:0][Width-1:0]   active_o
);

    logic [Depth-1:0][Width-1:0] shadow_q;
    logic [Depth-1:0][Width-1:0] active_q;

    // The caller guarantees wr_idx_i < Depth whenever wr_en_i is high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shadow_q <= {Depth{RstVal}};
            active_q <= {Depth{RstVal}};
        end else begin
            if (wr_en_i) begin
                shadow_q[wr_idx_i] <= wr_data_i;
            end
            if (copy_i) begin
                active_q <= shadow_q;
            end
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/s_pea_cfg_seq.sv
// Configuration sequencer: buffers host writes in shadow registers and swaps
// them into the active PE configuration once the array has drained.
module s_pea_cfg_seq #(
    parameter int unsigned N_PE          = 16,
    parameter int unsigned N_CFG_BITS_PE = pea_pkg::N_CFG_BITS_PE,
    parameter int unsigned N_BITS        = 32,
    parameter int unsigned DRAIN_CYCLES  = pea_pkg::CFG_DRAIN_CYCLES_DEFAULT
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  cfg_req_i,
    output logic                                  cfg_gnt_o,
    input  logic [$clog2(N_PE):0]                 cfg_addr_i,
    input  logic [N_BITS-1:0]                     cfg_wdata_i,
    input  logic                                  cfg_commit_i,
    output logic                                  cfg_busy_o,
    output logic                                  cfg_done_o,
    output logic                                  cfg_err_o,
    input  logic                                  pea_ready_i,
    input  logic [N_PE-1:0]                       pe_valid_i,
    output logic                                  pea_hold_o,
    output logic [N_PE-1:0][N_CFG_BITS_PE-1:0]    ctrl_pe_o,
    output logic [N_PE-1:0][N_BITS-1:0]           reg_const_o
);

    import pea_pkg::*;

    localparam int unsigned IDX_W = $clog2(N_PE);
    localparam int unsigned CNT_W = ($clog2(DRAIN_CYCLES + 1) > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    cfg_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dirty_q, dirty_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] wr_idx;
    logic             idx_ok;
    logic             wr_fire;
    logic             wr_ok;
    logic             ctrl_we;
    logic             const_we;
    logic             swap;

    assign wr_idx   = cfg_addr_i[IDX_W-1:0];
    assign idx_ok   = (32'(wr_idx) < N_PE);
    assign wr_fire  = (state_q == StIdle) && cfg_req_i;
    assign wr_ok    = wr_fire && idx_ok;
    assign ctrl_we  = wr_ok && !cfg_addr_i[IDX_W];
    assign const_we = wr_ok && cfg_addr_i[IDX_W];
    assign swap     = (state_q == StSwap);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dirty_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dirty_d = dirty_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (wr_ok) begin
                    dirty_d = 1'b1;
                end
                if (wr_fire && !idx_ok) begin
                    err_d = 1'b1;
                end
                // A write in the commit cycle is part of this commit.
                if (cfg_commit_i) begin
                    if (dirty_q || wr_ok) begin
                        state_d = StHold;
                        cnt_d   = CNT_W'(DRAIN_CYCLES);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StHold: begin
                if (pea_ready_i && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                // Leave as soon as the last required advance happens, so HOLD
                // spans exactly DRAIN_CYCLES advancing cycles when nothing is in flight.
                if ((cnt_d == '0) && (pe_valid_i == '0)) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                dirty_d = 1'b0;
                err_d   = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign cfg_gnt_o  = wr_fire;
    assign cfg_busy_o = (state_q != StIdle);
    assign cfg_done_o = (state_q == StDone);
    assign cfg_err_o  = err_q;
    assign pea_hold_o = (state_q == StHold) || (state_q == StSwap);

    cfg_shadow_bank #(
        .Width  (N_CFG_BITS_PE),
        .Depth  (N_PE),
        .RstVal (N_CFG_BITS_PE'(CTRL_NOP))
    ) u_ctrl_bank (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (ctrl_we),
        .wr_idx_i  (wr_idx),
        .wr_data_i (N_CFG_BITS_PE'(cfg_wdata_i)),
        .copy_i    (swap),
        .active_o  (ctrl_pe_o)
    );

    cfg_shadow_bank #(
        .Width  (N_BITS),
        .Depth  (N_PE),
        .RstVal ('0)
    ) u_const_bank (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (const_we),
        .wr_idx_i  (wr_idx),
        .wr_data_i (cfg_wdata_i),
        .copy_i    (swap),
        .active_o  (reg_const_o)
    );

endmodule
